yuanma_to_buma: RTL and testbench
=================================

YUANMA_TO_BUMA -- requirements
Module: yuanma_to_buma

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning word width in bits including sign (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  sign-magnitude word present on in_data.
REQ-005 SHALL provide port in_ready  output  1  block can accept a word.
REQ-006 SHALL provide port in_data  input  WIDTH  sign-magnitude word; bit WIDTH-1 is sign, bits WIDTH-2..0 are magnitude.
REQ-007 SHALL provide port out_valid  output  1  converted word present on out_data.
REQ-008 SHALL provide port out_ready  input  1  consumer accepts out_data.
REQ-009 SHALL provide port out_data  output  WIDTH  two's-complement equivalent of the accepted word.
REQ-010 SHALL provide port out_nz  output  1  accepted word was negative zero (sign 1, magnitude 0).

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a clock edge, SHALL capture the sign and magnitude, clear the bit counter and the seen_one flag, and go to SHIFT.
REQ-013 SHIFT: in_ready=0, out_valid=0; each edge SHALL process one magnitude bit, LSB first, over exactly WIDTH-1 edges.
REQ-014 Per-bit rule: if sign=0, result bit = magnitude bit; if sign=1, result bit = seen_one ? ~bit : bit; then seen_one |= bit.
REQ-015 Result bits SHALL be shifted into an internal register so that after WIDTH-1 edges bits WIDTH-2..0 hold the converted magnitude in order.
REQ-016 On the edge processing the last magnitude bit, SHALL set out_data[WIDTH-1] = sign AND (magnitude != 0), and go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly WIDTH-1 clock edges after the accepting edge (3 edges for WIDTH=4).
REQ-018 DONE: out_valid=1, in_ready=0; out_data and out_nz SHALL be held stable until out_ready=1 at an edge, then go to IDLE.
REQ-019 A new word SHALL NOT be accepted in the same cycle as an output handshake; minimum spacing between accepts is WIDTH+1 cycles.
REQ-020 Negative zero input SHALL produce out_data = 0.
REQ-021 Every sign-magnitude input SHALL be representable in the output; no overflow condition exists.
REQ-022 in_valid and in_data SHALL be ignored outside IDLE.
REQ-023 out_data SHALL be 0 in IDLE and SHIFT (no partial results exposed).

Reset
REQ-024 reset=1 SHALL immediately force IDLE, with in_ready=1, out_valid=0, out_data=0, out_nz=0, counter=0, and seen_one=0.
REQ-025 Reset asserted during SHIFT or DONE SHALL discard the word in flight; no out_valid SHALL follow for that word.

Configuration
REQ-026 With macro YUANMA_NEGZERO_FLAG_EN defined, out_nz SHALL equal sign AND (magnitude==0) of the accepted word, valid while out_valid=1 and 0 otherwise.
REQ-027 Without YUANMA_NEGZERO_FLAG_EN, out_nz SHALL be constant 0, the port SHALL remain present, and no detection logic SHALL be built.

Verification
REQ-028 WIDTH=4, in_data=0101 (+5), out_ready=1 -> out_valid rises 3 edges after accept, out_data=0101, out_nz=0.
REQ-029 in_data=1101 (-5) -> out_data=1011; in_data=1111 (-7) -> out_data=1001; in_data=1001 (-1) -> out_data=1111.
REQ-030 in_data=1000 (-0), macro defined -> out_data=0000, out_nz=1; macro undefined -> out_data=0000, out_nz=0.
REQ-031 Accept 1110 (-6) with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stays 1010; in_ready=0 throughout; new in_valid pulses ignored; IDLE follows the out_ready=1 edge.
REQ-032 Assert reset one edge into SHIFT -> in_ready=1 and out_valid=0 immediately; no output appears; the next word 0011 converts normally to 0011.
REQ-033 Exhaustive sweep of all 16 inputs with a random out_ready pattern -> each out_data matches the reference conversion; handshake count equals accept count.

Source files
------------

// File: rtl/yuanma_to_buma.sv
// yuanma_to_buma: converts a sign-magnitude word to two's complement with a
// bit-serial FSM (IDLE -> SHIFT -> DONE). The word is held in DONE until the
// consumer takes it.
//
// Parameters:
//   WIDTH      word width in bits including the sign bit (2..32)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   sign-magnitude word present on in_data
//   in_ready   block can accept a word (IDLE only)
//   in_data    sign-magnitude word; bit WIDTH-1 is the sign
//   out_valid  converted word present on out_data (DONE only)
//   out_ready  consumer accepts out_data
//   out_data   two's-complement word; 0 whenever out_valid is low
//   out_nz     accepted word was negative zero
// Build option:
//   YUANMA_NEGZERO_FLAG_EN  when defined, out_nz flags a negative-zero input.
//                           When undefined, out_nz is tied to 0.
module yuanma_to_buma #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nz
);
    localparam int MW = WIDTH - 1;          // magnitude width
    localparam int CW = $clog2(WIDTH);      // enough to count 0..MW-1

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [MW-1:0]    mag_q, mag_d;
    logic [MW-1:0]    res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             bit_cur;
    logic             rbit;
    logic             seen_nx;
    logic [MW-1:0]    res_sh;

`ifdef YUANMA_NEGZERO_FLAG_EN
    logic             nz_q, nz_d;
`endif

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        out_data_d = out_data_q;
`ifdef YUANMA_NEGZERO_FLAG_EN
        nz_d       = nz_q;
`endif

        // Negation done serially: bits up to and including the first 1 pass
        // through, every later bit inverts.
        bit_cur = mag_q[0];
        rbit    = (sign_q && seen_q) ? ~bit_cur : bit_cur;
        seen_nx = seen_q | bit_cur;
        // Result enters at the top and walks down, so the first (LSB) bit
        // lands at position 0 after MW shifts.
        res_sh         = res_q >> 1;
        res_sh[MW-1]   = rbit;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[WIDTH-1];
                    mag_d   = in_data[MW-1:0];
                    res_d   = '0;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                mag_d  = mag_q >> 1;
                res_d  = res_sh;
                seen_d = seen_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(MW - 1)) begin
                    // seen_nx now means "magnitude != 0"; negative zero
                    // therefore collapses to plain zero.
                    out_data_d = {sign_q & seen_nx, res_sh};
`ifdef YUANMA_NEGZERO_FLAG_EN
                    nz_d       = sign_q & ~seen_nx;
`endif
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_data_d = '0;
`ifdef YUANMA_NEGZERO_FLAG_EN
                    nz_d       = 1'b0;
`endif
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            out_data_q <= '0;
`ifdef YUANMA_NEGZERO_FLAG_EN
            nz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            out_data_q <= out_data_d;
`ifdef YUANMA_NEGZERO_FLAG_EN
            nz_q       <= nz_d;
`endif
        end
    end

    // Handshake flags decode straight from the state flop so reset reaches
    // them without waiting for a clock.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
`ifdef YUANMA_NEGZERO_FLAG_EN
    assign out_nz    = nz_q;
`else
    assign out_nz    = 1'b0;
`endif

endmodule

// File: tb/tb_yuanma_to_buma.sv
// Scoreboard bench for yuanma_to_buma (WIDTH=4). The driver pushes the
// hand-computed expected word at each accept; a monitor on the falling edge
// pops and compares whenever the output handshake is about to happen.
module tb_yuanma_to_buma;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_nz;

    typedef struct {
        logic [W-1:0] data;
        logic         nz;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_hs = 0;
    bit   rand_rdy = 1'b0;
    bit   prev_v = 1'b0;

`ifdef YUANMA_NEGZERO_FLAG_EN
    localparam logic NZ_EXP = 1'b1;
`else
    localparam logic NZ_EXP = 1'b0;
`endif

    // Hand-computed sign-magnitude -> two's complement table for WIDTH=4.
    logic [W-1:0] ref_tab [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                   4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};

    yuanma_to_buma #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nz(out_nz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Random consumer back-pressure for the sweep.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    if (!prev_v) chk("latency", cyc - exp_q[0].acc, W - 1);
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_nz", out_nz, exp_q[0].nz);
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_hs++;
                    end
                end
            end else begin
                chk("idle_out_data", out_data, 0);
                chk("idle_out_nz", out_nz, 0);
            end
            prev_v = out_valid;
        end
    end

    // Wait for IDLE, present one word for one edge, and record the accept.
    task automatic send(input logic [W-1:0] d, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 1, 0);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'hx;
        if (push) begin
            exp_q.push_back('{data: ref_tab[d], nz: (d == 4'b1000) ? NZ_EXP : 1'b0, acc: cyc});
            n_acc++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] dir [6] = '{4'b0101, 4'b1101, 4'b1111, 4'b1001, 4'b1000, 4'b0000};

        // Reset state.
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_nz", out_nz, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed conversions with the consumer always ready.
        foreach (dir[i]) send(dir[i], 1'b1);
        drain();

        // Stalled output: -6 held while new in_valid pulses are ignored.
        out_ready = 1'b0;
        send(4'b1110, 1'b1);
        repeat (W) @(posedge clk);
        #1 chk("stall_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_data  = 4'b0111;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, 4'b1010);
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("post_hs_idle", in_ready, 1);
        chk("post_hs_valid", out_valid, 0);
        drain();

        // Reset one edge into SHIFT discards the word in flight.
        send(4'b1101, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1 chk("no_output_after_rst", out_valid, 0);
        send(4'b0011, 1'b1);
        drain();

        // Sweep all 16 inputs under random back-pressure.
        rand_rdy = 1'b1;
        for (int v = 0; v < 16; v++) send(4'(v), 1'b1);
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        chk("hs_count", n_hs, n_acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule
